// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : 8N1 UART receiver (no parity), mid-bit sampling.
//
// The bit period comes from the same CLOCK_FREQ / BAUD_RATE pair as the
// transmitter, so a TX/RX pair built with identical parameters agrees on
// every bit boundary.
//
// Ports
//   clk            in   system clock, rising edge
//   n_rst          in   asynchronous active-low reset
//   serial_in      in   asynchronous serial line, idle high
//   uart_out       out  [7:0] last correctly framed byte (held between strobes)
//   uart_out_valid out  one-cycle strobe, uart_out updated in the same cycle
//   frame_err      out  one-cycle strobe when the stop bit samples low
//   rx_busy        out  high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       serial_in,
    output logic [7:0] uart_out,
    output logic       uart_out_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int SAMPLE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_TIME   = SAMPLE_TIME / 2;
    // Guard keeps the counter at least one bit wide for degenerate ratios.
    localparam int CNT_W       = (SAMPLE_TIME > 1) ? $clog2(SAMPLE_TIME) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_TIME - 1);
    localparam logic [CNT_W-1:0] CNT_FULL_LAST = CNT_W'(SAMPLE_TIME - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    // Two-flop synchronizer; both stages reset to the idle line level so a
    // low line right after reset needs two cycles before it looks like a start.
    logic sync1_q;
    logic rx_s_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       out_q,   out_d;
    logic             valid_q, valid_d;
    logic             ferr_q,  ferr_d;

    // -----------------------------------------------------------------------
    // Input synchronizer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            rx_s_q  <= sync1_q;
        end
    end

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            out_q     <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    //
    // The start bit is re-checked at HALF_TIME-1 and the counter cleared, so
    // every later sample lands SAMPLE_TIME cycles apart at mid-bit.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        out_d     = out_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (cnt_q == CNT_HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = ST_DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        // Line went back high before mid-start: a glitch.
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_DATA: begin
                if (cnt_q == CNT_FULL_LAST) begin
                    cnt_d   = '0;
                    // LSB arrives first, so shift in from the top.
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end

            ST_STOP: begin
                if (cnt_q == CNT_FULL_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        out_d   = shift_q;
                        valid_d = 1'b1;
                        // Leaving at mid-stop lets a back-to-back start bit
                        // be caught without any inter-frame gap.
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end

            ST_BREAK: begin
                // Hold here while the line stays low so a break is not
                // decoded as a stream of 0x00 frames.
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign uart_out       = out_q;
    assign uart_out_valid = valid_q;
    assign frame_err      = ferr_q;
    assign rx_busy        = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, 8N1, no parity; mirror of the transmit stage on the same serial link.
- Consumes the serial line (from the TX block in loopback, or from an external pin) and produces parallel bytes with a one-cycle valid strobe.
- Target clock is 50 MHz. The bit period is derived from the same parameters as the transmitter, so TX and RX instantiated with identical parameters interoperate bit-exactly.

Parameters:
- CLOCK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115_200, line rate in bit/s.
- Derived SAMPLE_TIME = CLOCK_FREQ / BAUD_RATE (integer division), in cycles per bit.
- Derived HALF_TIME = SAMPLE_TIME / 2.
- Derived counter width = $clog2(SAMPLE_TIME).

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- serial_in  input  1  asynchronous serial line; idle high.
- uart_out  output  8  last correctly received byte.
- uart_out_valid  output  1  one-cycle pulse; uart_out updated in the same cycle.
- frame_err  output  1  one-cycle pulse on a bad stop bit.
- rx_busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset is asynchronous, active-low (n_rst). Clock is clk.
- Reset values:
  - 2-flop synchronizer stages = 1 (rx_s = 1).
  - State = IDLE; bit counter and cycle counter = 0; shift register = 0.
  - uart_out = 8'h00; uart_out_valid = 0; frame_err = 0; rx_busy = 0.
- Synchronizer: serial_in passes through 2 flops to give rx_s. All decisions use rx_s only, so there are 2 cycles of input latency.
- State machine:
  - IDLE: if rx_s == 0, go to START with the cycle counter cleared. Otherwise stay.
  - START: count. At cnt == HALF_TIME-1, re-check rx_s.
    - If rx_s == 0, go to DATA with cnt = 0 and bit index = 0.
    - If rx_s == 1, treat as a false start (glitch) and go to IDLE. No outputs pulse.
  - DATA: at cnt == SAMPLE_TIME-1, sample rx_s into the shift register and clear cnt. Bits are LSB first, so shift in from the MSB side. After the 8th sample, go to STOP.
  - STOP: at cnt == SAMPLE_TIME-1, sample rx_s.
    - If rx_s == 1, load uart_out with the shift register, pulse uart_out_valid for one cycle, and go to IDLE.
    - If rx_s == 0, pulse frame_err for one cycle, leave uart_out unchanged, and go to BREAK.
  - BREAK: wait for rx_s == 1, then go to IDLE. This prevents a held-low line (break) from being decoded as repeated 0x00 frames.
  - Any illegal state encoding goes to IDLE.
- Sampling point: mid-bit. Each sample is taken HALF_TIME + k·SAMPLE_TIME cycles after the start edge is seen on rx_s.
- The cycle counter runs only outside IDLE and BREAK. It is cleared on every state transition and on every bit sample.
- Latency: uart_out_valid rises HALF_TIME + 9·SAMPLE_TIME + 2 cycles after the cycle in which the falling start edge is presented on serial_in. The exact count is ±1 depending on the synchronizer phase; benches allow a ±1 window.
- Back-to-back frames: the FSM returns to IDLE at mid-stop-bit, so a start bit immediately following the stop bit is detected. No gap is required between frames.
- uart_out holds its value between valid pulses. There is no downstream backpressure; a consumer must take the byte on the valid cycle or read the held value before the next valid.
- uart_out_valid and frame_err are never high in the same cycle.
- Reset asserted mid-frame: all state returns to reset values immediately and the partial byte is discarded. After n_rst deasserts, a line that is low is treated as a start edge only once the synchronizer has flushed (2 cycles).
- Throughout the Test Plan below, use CLOCK_FREQ=16, BAUD_RATE=1, giving SAMPLE_TIME=16 and HALF_TIME=8.

Test Plan:
- Single frame: drive 8N1 frame 0x55 with 16 cycles per bit. Expect uart_out=0x55 and one uart_out_valid pulse within the latency window. frame_err stays 0; rx_busy falls on the valid cycle.
- Loopback: connect the TX block's serial_out to serial_in (same parameters) and send 0xA5, 0x00, 0xFF, 0x3C back-to-back on tx_ready. Expect four valid pulses carrying exactly those bytes in order, and no frame_err.
- Glitch rejection: drive serial_in low for 4 cycles, then high. Expect rx_busy high for at most HALF_TIME+2 cycles, then IDLE, with no valid and no frame_err.
- Framing error: send 0x81 with the stop bit forced to 0, then hold the line low for 40 cycles, then release it high.
  - Expect one frame_err pulse and no valid pulse; uart_out keeps its previous value.
  - Expect the FSM to stay in BREAK (rx_busy=1) until the line rises.
  - Then a following 0x42 frame must be received correctly.
- Reset mid-frame: assert n_rst during DATA bit 3 of frame 0x99, release it, then send 0x66. Expect outputs at reset values during reset, no valid for the truncated frame, and uart_out=0x66 with one valid pulse afterwards.
- Baud tolerance: send 0xC3 with the bit period stretched to 17 cycles, then shrunk to 15 cycles. Expect 0xC3 received correctly in both cases.
